// File: rtl/xnor_conv_accum.sv
// XNOR-popcount convolution PE: per-channel +/-1 dot product,
// saturating accumulation over in_last-delimited groups, binarised out.
module xnor_conv_accum #(
  parameter int WIN   = 25,
  parameter int ACC_W = 16
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIN-1:0]   in_act,
  input  logic [WIN-1:0]   in_wgt,
  input  logic             in_last,
  input  logic [ACC_W-1:0] cfg_thresh,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] out_sum,
  output logic             out_bit,
  output logic [7:0]       out_count,
  output logic             out_ovf
);

  localparam int PC_W = $clog2(WIN + 1);
  localparam int TW   = PC_W + 2;
  localparam int XW   = ACC_W + 1 - TW;

  localparam logic signed [TW-1:0] WIN_S = TW'(WIN);
  localparam logic [ACC_W-1:0] SMAX = {1'b0, {(ACC_W-1){1'b1}}};
  localparam logic [ACC_W-1:0] SMIN = {1'b1, {(ACC_W-1){1'b0}}};

  logic [WIN-1:0]   match;
  logic [PC_W-1:0]  pc;
  logic [TW-1:0]    term;

  always_comb begin
    match = in_act ~^ in_wgt;
    pc    = '0;
    for (int i = 0; i < WIN; i++) begin
      pc = pc + PC_W'(match[i]);
    end
    term = $signed({1'b0, pc, 1'b0}) - WIN_S;
  end

  logic          s1_valid;
  logic          s1_last;
  logic [TW-1:0] s1_term;
  logic          stall;

  assign stall    = s1_valid && s1_last && out_valid && !out_ready;
  assign in_ready = !stall;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      s1_valid <= 1'b0;
      s1_last  <= 1'b0;
      s1_term  <= '0;
    end else if (!stall) begin
      s1_valid <= in_valid;
      if (in_valid) begin
        s1_last <= in_last;
        s1_term <= term;
      end
    end
  end

  logic [ACC_W-1:0] acc;
  logic [7:0]       cnt;
  logic             ovf;

  logic [ACC_W:0]   wide;
  logic             clamp;
  logic [ACC_W-1:0] sum;
  logic [7:0]       cnt_nx;
  logic             ovf_nx;
  logic             fire;
  logic             emit;

  // One guard bit is enough: |term| never exceeds the accumulator range.
  always_comb begin
    wide   = {acc[ACC_W-1], acc}
           + {{XW{s1_term[TW-1]}}, s1_term};
    clamp  = wide[ACC_W] != wide[ACC_W-1];
    sum    = wide[ACC_W-1:0];
    if (clamp) sum = wide[ACC_W] ? SMIN : SMAX;
    cnt_nx = (cnt == 8'hff) ? cnt : cnt + 8'd1;
    ovf_nx = ovf | clamp;
    fire   = s1_valid && !stall;
    emit   = fire && s1_last;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      acc <= '0;
      cnt <= '0;
      ovf <= 1'b0;
    end else if (fire) begin
      if (s1_last) begin
        acc <= '0;
        cnt <= '0;
        ovf <= 1'b0;
      end else begin
        acc <= sum;
        cnt <= cnt_nx;
        ovf <= ovf_nx;
      end
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      out_valid <= 1'b0;
      out_sum   <= '0;
      out_bit   <= 1'b0;
      out_count <= '0;
      out_ovf   <= 1'b0;
    end else if (emit) begin
      out_valid <= 1'b1;
      out_sum   <= sum;
      out_bit   <= $signed(sum) >= $signed(cfg_thresh);
      out_count <= cnt_nx;
      out_ovf   <= ovf_nx;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_xnor_conv_accum.sv
// Scoreboard bench for xnor_conv_accum (WIN=25, ACC_W=8):
// directed groups, backpressure, saturation and mid-group reset.
module tb_xnor_conv_accum;

  localparam int WIN   = 25;
  localparam int ACC_W = 8;

  logic             clock = 1'b0;
  logic             reset_n;
  logic             in_valid;
  logic             in_ready;
  logic [WIN-1:0]   in_act;
  logic [WIN-1:0]   in_wgt;
  logic             in_last;
  logic [ACC_W-1:0] cfg_thresh;
  logic             out_valid;
  logic             out_ready;
  logic [ACC_W-1:0] out_sum;
  logic             out_bit;
  logic [7:0]       out_count;
  logic             out_ovf;

  xnor_conv_accum #(.WIN(WIN), .ACC_W(ACC_W)) dut (
    .clock      (clock),
    .reset_n    (reset_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_act     (in_act),
    .in_wgt     (in_wgt),
    .in_last    (in_last),
    .cfg_thresh (cfg_thresh),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_sum    (out_sum),
    .out_bit    (out_bit),
    .out_count  (out_count),
    .out_ovf    (out_ovf)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [ACC_W-1:0] sum;
    logic             b;
    logic [7:0]       cnt;
    logic             ovf;
  } exp_t;

  exp_t sb[$];
  int   pops[$];
  int   nvec  = 0;
  int   nerr  = 0;
  int   npush = 0;
  int   cyc   = 0;

  localparam logic [WIN-1:0] ONES = {WIN{1'b1}};
  localparam logic [WIN-1:0] ZERO = '0;
  localparam logic [WIN-1:0] P1   = 25'h0001fff;

  always @(posedge clock) cyc++;

  always @(negedge clock) begin
    if (reset_n && out_valid && out_ready) begin
      nvec++;
      if (sb.size() == 0) begin
        nerr++;
        $display("FAIL extra_result got sum=%0d cnt=%0d",
                 $signed(out_sum), out_count);
      end else begin
        exp_t e;
        e = sb.pop_front();
        if (out_sum !== e.sum || out_bit !== e.b ||
            out_count !== e.cnt || out_ovf !== e.ovf) begin
          nerr++;
          $display("FAIL result got sum=%0d bit=%0b cnt=%0d ovf=%0b want sum=%0d bit=%0b cnt=%0d ovf=%0b",
                   $signed(out_sum), out_bit, out_count, out_ovf,
                   $signed(e.sum), e.b, e.cnt, e.ovf);
        end
      end
      pops.push_back(cyc);
    end
  end

  task automatic check(input string name, input longint got,
                       input longint want);
    nvec++;
    if (got != want) begin
      nerr++;
      $display("FAIL %s got %0d want %0d", name, got, want);
    end
  endtask

  task automatic expect_res(input int s, input logic b,
                            input int c, input logic o);
    exp_t e;
    e.sum = ACC_W'(s);
    e.b   = b;
    e.cnt = 8'(c);
    e.ovf = o;
    sb.push_back(e);
    npush++;
  endtask

  task automatic send(input logic [WIN-1:0] a,
                      input logic [WIN-1:0] w, input logic l);
    int b;
    in_valid = 1'b1;
    in_act   = a;
    in_wgt   = w;
    in_last  = l;
    b = 0;
    @(negedge clock);
    while (!in_ready && b < 100) begin
      b++;
      @(negedge clock);
    end
    if (!in_ready) begin
      nvec++;
      nerr++;
      $display("FAIL in_ready_timeout got 0 want 1");
    end
    @(posedge clock);
    #1;
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic drain(input string name);
    for (int i = 0; i < 50 && sb.size() != 0; i++) begin
      @(posedge clock);
    end
    @(posedge clock);
    #1;
    check(name, sb.size(), 0);
  endtask

  task automatic check_gap(input string name);
    int n;
    n = pops.size();
    if (n < 2) check(name, n, 2);
    else check(name, pops[n-1] - pops[n-2], 1);
  endtask

  initial begin
    reset_n    = 1'b0;
    in_valid   = 1'b0;
    in_act     = '0;
    in_wgt     = '0;
    in_last    = 1'b0;
    cfg_thresh = '0;
    out_ready  = 1'b1;
    repeat (2) @(negedge clock);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_sum", out_sum, 0);
    check("rst_out_bit", out_bit, 0);
    check("rst_out_count", out_count, 0);
    check("rst_out_ovf", out_ovf, 0);
    check("rst_in_ready", in_ready, 1);
    @(posedge clock);
    #1;
    reset_n = 1'b1;

    expect_res(25, 1, 1, 0);
    send(ONES, ONES, 1);
    drain("single_beat");

    expect_res(-75, 0, 3, 0);
    send(ZERO, ONES, 0);
    send(ZERO, ONES, 0);
    send(ZERO, ONES, 1);
    drain("neg_group");

    cfg_thresh = 8'd4;
    expect_res(4, 1, 4, 0);
    expect_res(25, 1, 1, 0);
    send(P1, ONES, 0);
    send(P1, ONES, 0);
    send(P1, ONES, 0);
    send(P1, ONES, 1);
    send(ONES, ONES, 1);
    drain("b2b_groups");
    check_gap("b2b_gap");

    out_ready = 1'b0;
    expect_res(-25, 0, 1, 0);
    send(ZERO, ONES, 1);
    expect_res(51, 1, 3, 0);
    send(ONES, ONES, 0);
    send(ONES, ONES, 0);
    send(P1, ONES, 1);
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      check("bp_in_ready", in_ready, 0);
      check("bp_hold_valid", out_valid, 1);
      check("bp_hold_sum", out_sum, 8'hE7);
    end
    @(posedge clock);
    #1;
    out_ready = 1'b1;
    drain("backpressure");
    check_gap("bp_gap");

    expect_res(127, 1, 6, 1);
    for (int i = 0; i < 5; i++) send(ONES, ONES, 0);
    send(ONES, ONES, 1);
    expect_res(-25, 0, 1, 0);
    send(ZERO, ONES, 1);
    drain("saturation");

    send(ONES, ONES, 0);
    send(ONES, ONES, 0);
    @(posedge clock);
    #1;
    reset_n = 1'b0;
    @(negedge clock);
    check("mid_rst_valid", out_valid, 0);
    check("mid_rst_sum", out_sum, 0);
    check("mid_rst_count", out_count, 0);
    check("mid_rst_ready", in_ready, 1);
    @(posedge clock);
    #1;
    reset_n = 1'b1;
    expect_res(25, 1, 1, 0);
    send(ONES, ONES, 1);
    drain("after_reset");

    check("no_loss_dup", pops.size(), npush);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
